// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I requests into 32-bit words and queues them in an addressed FIFO
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_kind,
    input  logic [2:0]                 in_alu,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [12:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          alu_ok, legal, accept, push, pop;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   enc;
    always_comb begin
        alu_ok = ~in_alu[2] | (in_alu == 3'b101);
        f3     = in_alu == 3'b101 ? 3'b010 :
                 in_alu == 3'b011 ? 3'b110 :
                 in_alu == 3'b010 ? 3'b111 : 3'b000;
        f7     = in_alu == 3'b001 ? 7'b0100000 : 7'b0000000;
        legal  = in_kind == 3'd0 ? alu_ok :
                 in_kind == 3'd1 ? alu_ok && in_alu != 3'b001 :
                 in_kind == 3'd2 || in_kind == 3'd3 || in_kind == 3'd4;
        enc    = in_kind == 3'd0 ? {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011} :
                 in_kind == 3'd1 ? {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011} :
                 in_kind == 3'd2 ? {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011} :
                 in_kind == 3'd3 ? {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011} :
                                   {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], 7'b1100011};
    end
    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign out_instr = mem[rp];
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;
    always_ff @(posedge clk)
        if (push) mem[wp] <= enc;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            err      <= 1'b0;
            out_addr <= BASE_ADDR;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp       <= rp + 1'b1;
                out_addr <= out_addr + 32'd4;
            end
            count <= count + CW'(push) - CW'(pop);
            if (accept && !legal) err <= 1'b1;
        end
    end
endmodule
